// File: rtl/axi_lite_cmd_master.sv
// Command-to-AXI-Lite master bridge: one AXI-Lite transaction per command,
// with a sticky watchdog flag for slaves that stall a handshake phase.
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic                  rsp_write,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  timeout_err,
   output logic                  AWVALID,
   output logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic                  AWREADY,
   output logic                  WVALID,
   output logic [DATA_WIDTH-1:0] WDATA,
   input  logic                  WREADY,
   input  logic                  BVALID,
   input  logic [1:0]            BRESP,
   output logic                  BREADY,
   output logic                  ARVALID,
   output logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic                  ARREADY,
   input  logic                  RVALID,
   input  logic [DATA_WIDTH-1:0] RDATA,
   input  logic [1:0]            RRESP,
   output logic                  RREADY
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
   localparam bit WD_EN = (TIMEOUT != 0);

   typedef enum logic [2:0] {
      IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  write_q, write_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            resp_q, resp_d;
   logic                  rwrite_q, rwrite_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic                  aw_hs, w_hs, wait_st;

   assign cmd_ready   = (state_q == IDLE) & ~ARESET;
   assign AWVALID     = (state_q == WR_AW_W) & ~aw_done_q;
   assign WVALID      = (state_q == WR_AW_W) & ~w_done_q;
   assign BREADY      = (state_q == WR_B);
   assign ARVALID     = (state_q == RD_AR);
   assign RREADY      = (state_q == RD_R);
   assign rsp_valid   = (state_q == RSP);
   assign AWADDR      = addr_q;
   assign ARADDR      = addr_q;
   assign WDATA       = wdata_q;
   assign rsp_write   = rwrite_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_resp    = resp_q;
   assign timeout_err = err_q;

   assign aw_hs = AWVALID & AWREADY;
   assign w_hs  = WVALID & WREADY;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      write_d   = write_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      rwrite_d  = rwrite_q;
      unique case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d    = cmd_addr;
               wdata_d   = cmd_wdata;
               write_d   = cmd_write;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = cmd_write ? WR_AW_W : RD_AR;
            end
         end
         WR_AW_W: begin
            aw_done_d = aw_done_q | aw_hs;
            w_done_d  = w_done_q | w_hs;
            if (aw_done_d && w_done_d) begin
               state_d = WR_B;
            end
         end
         WR_B: begin
            if (BVALID) begin
               resp_d   = BRESP;
               rdata_d  = '0;
               rwrite_d = write_q;
               state_d  = RSP;
            end
         end
         RD_AR: begin
            if (ARREADY) begin
               state_d = RD_R;
            end
         end
         RD_R: begin
            if (RVALID) begin
               rdata_d  = RDATA;
               resp_d   = RRESP;
               rwrite_d = write_q;
               state_d  = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Counter is zero outside wait phases, so every entry starts from zero.
   always_comb begin
      wait_st = (state_q == WR_AW_W) || (state_q == WR_B) ||
                (state_q == RD_AR) || (state_q == RD_R);
      cnt_d = cnt_q;
      if (!wait_st || (state_d != state_q)) begin
         cnt_d = '0;
      end else if (cnt_q != TLIM) begin
         cnt_d = cnt_q + CW'(1);
      end
      err_d = err_q | (WD_EN && (cnt_d == TLIM));
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= '0;
         rwrite_q  <= 1'b0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         rwrite_q  <= rwrite_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

Command-to-AXI-Lite master bridge that sits directly upstream of the SoC's AXI-Lite slave port. It accepts single read/write commands on a valid/ready command interface and runs exactly one AXI-Lite transaction per command. It returns the read data and response code on a valid/ready response interface. A watchdog flags slaves that stall a handshake phase.

## Interface
Parameters:
- ADDR_WIDTH, 32, AXI and command address width
- DATA_WIDTH, 32, AXI and command data width
- TIMEOUT, 256, cycles allowed per AXI wait phase before flagging; 0 disables the watchdog

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  target byte address
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_write  out  1  echo of cmd_write for this response
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
- rsp_resp  out  2  BRESP or RRESP captured from the slave
- timeout_err  out  1  sticky watchdog flag
- AWVALID, AWADDR  out  1 / ADDR_WIDTH  write address channel
- AWREADY  in  1  write address channel
- WVALID, WDATA  out  1 / DATA_WIDTH  write data channel
- WREADY  in  1  write data channel
- BVALID, BRESP  in  1 / 2  write response channel
- BREADY  out  1  write response channel
- ARVALID, ARADDR  out  1 / ADDR_WIDTH  read address channel
- ARREADY  in  1  read address channel
- RVALID, RDATA, RRESP  in  1 / DATA_WIDTH / 2  read data channel
- RREADY  out  1  read data channel

## Operation
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP. All outputs are registered or decoded from state.
- IDLE: cmd_ready = 1. On accept:
  - Latch addr, wdata and write into holding registers.
  - Go to WR_AW_W (write) or RD_AR (read).
- WR_AW_W:
  - AWVALID and WVALID rise together.
  - Each deasserts independently on its own handshake. Two done-bits track completion; the other channel keeps its VALID held.
  - If both channels complete, or the second completes, go to WR_B.
- WR_B: BREADY = 1. On BVALID, capture BRESP into rsp_resp, clear rsp_rdata, go to RSP.
- RD_AR: ARVALID = 1. On ARREADY, go to RD_R.
- RD_R: RREADY = 1. On RVALID, capture RDATA and RRESP, go to RSP.
- RSP: rsp_valid = 1 with stable rsp_* fields. On rsp_ready, go to IDLE.
- Exactly one outstanding transaction; cmd_ready = 0 in every state except IDLE.
- VALID signals never drop before their handshake. AWADDR, WDATA and ARADDR are driven from the holding registers and stay stable while VALID is high.
- Watchdog:
  - The counter clears on entry to each of WR_AW_W, WR_B, RD_AR and RD_R, and increments every cycle spent in that state without phase completion. It saturates.
  - When the count reaches TIMEOUT, timeout_err sets and stays set until ARESET. The transaction is not aborted; the bridge keeps waiting.
- Non-OKAY responses (SLVERR/DECERR) pass through unmodified in rsp_resp. No retry.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE.
  - Reset values: AWVALID = WVALID = ARVALID = 0, BREADY = RREADY = 0, cmd_ready = 0 during reset then 1, rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_resp = 0, timeout_err = 0, AWADDR/WDATA/ARADDR = 0.
- Reset mid-transaction drops all VALIDs immediately and discards the command. No response is issued.
- Command accepted at edge N: the first AXI VALID is high in cycle N+1.
- Zero-wait slave, read: ARVALID in cycle N+1, RREADY in cycle N+2, rsp_valid in cycle N+3 at the earliest, provided the slave presents RVALID in N+2.
- Zero-wait slave, write: AW/W in cycle N+1, BREADY in cycle N+2, rsp_valid in cycle N+3 at the earliest.
- After a response handshake at edge M, cmd_ready = 1 in cycle M+1. The maximum throughput is one command per 4 cycles.
- BREADY and RREADY are never high outside WR_B and RD_R; early BVALID or RVALID waits.

## Test plan
- Write, zero-wait slave: cmd write 0x0000_0004 / 0xDEAD_BEEF.
  - Required: AWVALID and WVALID both high 1 cycle later with AWADDR = 0x4, WDATA = 0xDEADBEEF.
  - Required: rsp_valid 3 cycles after accept with rsp_write = 1, rsp_resp = 2'b00, rsp_rdata = 0.
- Read back, zero-wait slave: cmd read 0x4.
  - Required: rsp_rdata = 0xDEADBEEF, rsp_resp = 0 after 3 cycles.
  - Required: cmd_ready low from accept until 1 cycle after rsp handshake.
- Skewed write: AWREADY at cycle 1, WREADY at cycle 5.
  - Required: AWVALID drops after cycle 1, WVALID is held through cycle 5, BREADY rises only in cycle 6.
- Backpressure: hold rsp_ready = 0 for 10 cycles after rsp_valid.
  - Required: rsp fields stable, cmd_ready = 0, no new AXI VALID. Release -> IDLE next cycle.
- Watchdog, TIMEOUT = 8: slave never asserts ARREADY.
  - Required: timeout_err = 1 after 8 cycles in RD_AR, ARVALID still high.
  - Required: late ARREADY completes the read normally and timeout_err stays 1.
- Reset mid-write: assert ARESET while WVALID is high and awaiting WREADY.
  - Required: all VALIDs 0 immediately, no rsp_valid. After release, cmd_ready = 1 and a new read completes with correct data.
